// File: rtl/mimo_output_collector_if.sv
// Output stream bundle of mimo_output_collector.
//
// Handshake: the master holds o_valid, o_data and o_last steady until the
// slave accepts the word. A word transfers at a rising clock edge where
// o_valid && i_ready are both high. i_ready may be driven without looking
// at o_valid; i_ready while o_valid is low has no effect.
//
// Signals:
//   o_valid  master->slave  head word available
//   o_data   master->slave  12-bit detected-symbol word
//   o_last   master->slave  word is the last vector of its frame
//   i_ready  slave->master  consumer accepts the head word
interface mimo_output_collector_if;
    logic        o_valid;
    logic        i_ready;
    logic [11:0] o_data;
    logic        o_last;

    modport master (output o_valid, output o_data, output o_last, input i_ready);
    modport slave  (input o_valid, input o_data, input o_last, output i_ready);
endinterface

// File: rtl/mimo_output_collector.sv
// mimo_output_collector: receive-side sink for the MIMO detector output.
// Captures each 12-bit detected-symbol word on i_det_valid, tags the last
// vector of every frame, and buffers words in a show-ahead FIFO drained by a
// valid/ready consumer. The detector cannot be stalled, so words arriving
// while the FIFO is full are dropped and counted.
//
// Optional feature macro: OUT_GRAY_DECODE_EN -- when defined, every 3-bit
// antenna field is Gray-decoded on the read side (combinational).
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   i_det_valid detector output-ready strobe, one word per high cycle
//   i_det_data  detector word: [11:9] ant0 .. [2:0] ant3
//   i_clear     synchronous clear of FIFO, counters and sticky flags
//   out         output stream (o_valid/o_data/o_last/i_ready)
//   o_level     FIFO occupancy
//   o_count     vectors seen from the detector, wraps
//   o_overflow  sticky: a detector word was dropped
//   o_drop_cnt  dropped words, saturating at 255
module mimo_output_collector #(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 11,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_det_valid,
    input  logic [11:0]              i_det_data,
    input  logic                     i_clear,
    mimo_output_collector_if.master  out,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [CNT_W-1:0]         o_count,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int FI_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [12:0]     mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [FI_W-1:0] frame_idx;

    logic        empty;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        drop;
    logic        tag_last;
    logic [12:0] head;

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && out.i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = i_det_valid && (!full || pop);
    assign drop     = i_det_valid && full && !pop;
    assign tag_last = (frame_idx == FI_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_idx  <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else if (i_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_idx  <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Dropped words still advance frame position and the vector
            // count so that later frames keep their alignment.
            if (i_det_valid) begin
                o_count   <= o_count + 1'b1;
                frame_idx <= tag_last ? '0 : frame_idx + 1'b1;
            end
            if (drop) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != 8'hFF) begin
                    o_drop_cnt <= o_drop_cnt + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: nothing is visible until written.
    always_ff @(posedge clk) begin
        if (push_ok && !i_clear && !rst) begin
            mem[wr_ptr[AW-1:0]] <= {tag_last, i_det_data};
        end
    end

    // Gate the head with empty so outputs read zero when nothing is held.
    assign head      = empty ? 13'd0 : mem[rd_ptr[AW-1:0]];
    assign out.o_valid = !empty;
    assign out.o_last  = head[12];
    assign o_level   = wr_ptr - rd_ptr;

`ifdef OUT_GRAY_DECODE_EN
    function automatic logic [11:0] gray_decode(input logic [11:0] g);
        logic [11:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b[3*i+2] = g[3*i+2];
            b[3*i+1] = g[3*i+2] ^ g[3*i+1];
            b[3*i]   = g[3*i+2] ^ g[3*i+1] ^ g[3*i];
        end
        return b;
    endfunction

    assign out.o_data = gray_decode(head[11:0]);
`else
    assign out.o_data = head[11:0];
`endif

endmodule
